// File: rtl/mips_store_checker_if.sv
// rtl/mips_store_checker_if.sv - store snoop and table-config bus of the MIPS store checker
interface mips_store_checker_if #(
   parameter int DATA_W  = 32,
   parameter int NUM_EXP = 8
);
   localparam int IDX_W = $clog2(NUM_EXP + 1);

   // Table programming and run control
   logic              cfg_we;
   logic [IDX_W-1:0]  cfg_idx;
   logic [DATA_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic [IDX_W-1:0]  exp_count;
   logic              start;

   // Data-memory write port of the processor under test
   logic              memwrite;
   logic [DATA_W-1:0] aluout;
   logic [DATA_W-1:0] writedata;

   modport master (
      output cfg_we, cfg_idx, cfg_addr, cfg_data, exp_count, start,
      output memwrite, aluout, writedata
   );

   modport slave (
      input cfg_we, cfg_idx, cfg_addr, cfg_data, exp_count, start,
      input memwrite, aluout, writedata
   );
endinterface

// File: rtl/mips_store_checker.sv
// rtl/mips_store_checker.sv - in-order store checker with watchdog; optional MIPS_STORE_CHECKER_DUP_FILTER_EN
module mips_store_checker #(
   parameter int DATA_W     = 32,
   parameter int NUM_EXP    = 8,
   parameter int MAX_CYCLES = 1000,
   localparam int IDX_W     = $clog2(NUM_EXP + 1),
   localparam int CNT_W     = $clog2(MAX_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                reset_n,
   mips_store_checker_if.slave bus,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout,
   output logic [IDX_W-1:0]    match_count,
   output logic [CNT_W-1:0]    cycle_count,
   output logic [DATA_W-1:0]   err_addr,
   output logic [DATA_W-1:0]   err_data,
   output logic                overrun
);

   // Table index width and depth rounded to a power of two so any slice of the index is in range
   localparam int TI_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
   localparam int TBL_D = 1 << TI_W;

   localparam logic [IDX_W-1:0] NUM_EXP_C = IDX_W'(NUM_EXP);
   localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_PASS = 3'd2,
      S_FAIL = 3'd3,
      S_TOUT = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  match_q, match_d;
   logic [IDX_W-1:0]  exp_q, exp_d;
   logic [CNT_W-1:0]  cyc_q, cyc_d;
   logic [DATA_W-1:0] err_addr_q, err_addr_d;
   logic [DATA_W-1:0] err_data_q, err_data_d;
   logic              overrun_q, overrun_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;
   logic              tout_q, tout_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] tbl_addr_q [TBL_D];
   logic [DATA_W-1:0] tbl_data_q [TBL_D];

   logic              tbl_we;
   logic              store_v;
   logic              store_ok;
   logic [IDX_W-1:0]  exp_clip;
   logic [IDX_W-1:0]  match_inc;
   logic [CNT_W-1:0]  cyc_inc;

   assign tbl_we    = (state_q == S_IDLE) && bus.cfg_we && (bus.cfg_idx < NUM_EXP_C);
   assign exp_clip  = (bus.exp_count > NUM_EXP_C) ? NUM_EXP_C : bus.exp_count;
   assign match_inc = match_q + IDX_W'(1);
   assign cyc_inc   = cyc_q + CNT_W'(1);
   assign store_ok  = (bus.aluout == tbl_addr_q[match_q[TI_W-1:0]]) &&
                      (bus.writedata == tbl_data_q[match_q[TI_W-1:0]]);

`ifdef MIPS_STORE_CHECKER_DUP_FILTER_EN
   logic              hist_v_q, hist_v_d;
   logic [DATA_W-1:0] hist_addr_q, hist_addr_d;
   logic [DATA_W-1:0] hist_data_q, hist_data_d;

   // Remember last cycle's store; a stalled store repeats it and is treated as one
   always_comb begin
      hist_v_d    = bus.memwrite && !bus.start;
      hist_addr_d = bus.aluout;
      hist_data_d = bus.writedata;
   end

   // History flops for the duplicate filter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_v_q    <= 1'b0;
         hist_addr_q <= '0;
         hist_data_q <= '0;
      end else begin
         hist_v_q    <= hist_v_d;
         hist_addr_q <= hist_addr_d;
         hist_data_q <= hist_data_d;
      end
   end

   assign store_v = bus.memwrite &&
                    !(hist_v_q && (bus.aluout == hist_addr_q) && (bus.writedata == hist_data_q));
`else
   assign store_v = bus.memwrite;
`endif

   // Expected-table storage; writable only from IDLE and deliberately not reset
   always_ff @(posedge clk) begin
      if (tbl_we) begin
         tbl_addr_q[bus.cfg_idx[TI_W-1:0]] <= bus.cfg_addr;
         tbl_data_q[bus.cfg_idx[TI_W-1:0]] <= bus.cfg_data;
      end
   end

   // Next-state and verdict computation; start overrides everything outside reset
   always_comb begin
      state_d    = state_q;
      match_d    = match_q;
      exp_d      = exp_q;
      cyc_d      = cyc_q;
      err_addr_d = err_addr_q;
      err_data_d = err_data_q;
      overrun_d  = overrun_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      tout_d     = tout_q;
      done_d     = done_q;

      if (bus.start) begin
         state_d    = S_RUN;
         match_d    = '0;
         exp_d      = exp_clip;
         cyc_d      = '0;
         err_addr_d = '0;
         err_data_d = '0;
         overrun_d  = 1'b0;
         pass_d     = 1'b0;
         fail_d     = 1'b0;
         tout_d     = 1'b0;
         done_d     = 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (cyc_q < MAX_C) cyc_d = cyc_inc;
               if (exp_q == '0) begin
                  state_d = S_PASS;
               end else if (store_v) begin
                  if (store_ok) begin
                     match_d = match_inc;
                     if (match_inc == exp_q) state_d = S_PASS;
                  end else begin
                     state_d    = S_FAIL;
                     err_addr_d = bus.aluout;
                     err_data_d = bus.writedata;
                  end
               end
               // Watchdog loses to a verdict reached on the same edge
               if ((state_d == S_RUN) && (cyc_inc == MAX_C)) state_d = S_TOUT;
               pass_d = (state_d == S_PASS);
               fail_d = (state_d == S_FAIL);
               tout_d = (state_d == S_TOUT);
               done_d = (state_d != S_RUN);
            end
            S_PASS: begin
               if (store_v) overrun_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // State and output registers; reset aborts to IDLE with every output low
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         match_q    <= '0;
         exp_q      <= '0;
         cyc_q      <= '0;
         err_addr_q <= '0;
         err_data_q <= '0;
         overrun_q  <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         tout_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         exp_q      <= exp_d;
         cyc_q      <= cyc_d;
         err_addr_q <= err_addr_d;
         err_data_q <= err_data_d;
         overrun_q  <= overrun_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         tout_q     <= tout_d;
         done_q     <= done_d;
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign timeout     = tout_q;
   assign match_count = match_q;
   assign cycle_count = cyc_q;
   assign err_addr    = err_addr_q;
   assign err_data    = err_data_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_mips_store_checker.sv
// tb/tb_mips_store_checker.sv - directed table-driven bench for mips_store_checker
module tb_mips_store_checker;

   localparam int DATA_W = 32;
   localparam int NUM_EXP = 8;
   localparam int MAXC = 20;
   localparam int IDX_W = $clog2(NUM_EXP + 1);
   localparam int CNT_W = $clog2(MAXC + 1);

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic done, pass, fail, timeout, overrun;
   logic [IDX_W-1:0] match_count;
   logic [CNT_W-1:0] cycle_count;
   logic [DATA_W-1:0] err_addr, err_data;

   int checks = 0;
   int errors = 0;

   mips_store_checker_if #(.DATA_W(DATA_W), .NUM_EXP(NUM_EXP)) bus ();

   mips_store_checker #(.DATA_W(DATA_W), .NUM_EXP(NUM_EXP), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus),
      .done(done), .pass(pass), .fail(fail), .timeout(timeout),
      .match_count(match_count), .cycle_count(cycle_count),
      .err_addr(err_addr), .err_data(err_data), .overrun(overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] t_addr, t_data;
      logic [3:0]  exp_cnt;
      logic [31:0] s_addr, s_data;
      logic        e_pass, e_fail, e_done, e_over;
      logic [3:0]  e_match;
      logic [31:0] e_eaddr, e_edata;
   } vec_t;

   function automatic vec_t mk(string n, logic [31:0] ta, logic [31:0] td, logic [3:0] ec,
                               logic [31:0] sa, logic [31:0] sd, logic ep, logic ef,
                               logic ed, logic eo, logic [3:0] em, logic [31:0] xa,
                               logic [31:0] xd);
      vec_t v;
      v.name = n; v.t_addr = ta; v.t_data = td; v.exp_cnt = ec; v.s_addr = sa; v.s_data = sd;
      v.e_pass = ep; v.e_fail = ef; v.e_done = ed; v.e_over = eo; v.e_match = em;
      v.e_eaddr = xa; v.e_edata = xd;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      #1;
   endtask

   task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic [31:0] a, input logic [31:0] d);
      bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_addr = a; bus.cfg_data = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic do_start(input logic [IDX_W-1:0] n);
      bus.start = 1'b1; bus.exp_count = n;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bus.memwrite = 1'b1; bus.aluout = a; bus.writedata = d;
      tick();
      bus.memwrite = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = mk("match1",  32'h54, 32'h7, 4'd1, 32'h54, 32'h7, 1, 0, 1, 0, 4'd1, 0, 0);
      vecs[1] = mk("baddata", 32'h54, 32'h7, 4'd1, 32'h54, 32'h8, 0, 1, 1, 0, 4'd0, 32'h54, 32'h8);
      vecs[2] = mk("badaddr", 32'h54, 32'h7, 4'd1, 32'h58, 32'h7, 0, 1, 1, 0, 4'd0, 32'h58, 32'h7);
      vecs[3] = mk("wide",    32'hFFFFFFFC, 32'hDEADBEEF, 4'd1, 32'hFFFFFFFC, 32'hDEADBEEF,
                   1, 0, 1, 0, 4'd1, 0, 0);
      vecs[4] = mk("partial", 32'h10, 32'h3, 4'd2, 32'h10, 32'h3, 0, 0, 0, 0, 4'd1, 0, 0);
      vecs[5] = mk("exp0",    32'h10, 32'h3, 4'd0, 32'h44, 32'h1, 1, 0, 1, 1, 4'd0, 0, 0);
      vecs[6] = mk("clip",    32'h20, 32'h5, 4'd15, 32'h20, 32'h5, 0, 0, 0, 0, 4'd1, 0, 0);

      bus.cfg_we = 0; bus.cfg_idx = 0; bus.cfg_addr = 0; bus.cfg_data = 0;
      bus.exp_count = 0; bus.start = 0; bus.memwrite = 0; bus.aluout = 0; bus.writedata = 0;

      // Reset state
      #2;
      check("rst_done", done, 0);
      check("rst_flags", {pass, fail, timeout, overrun}, 0);
      check("rst_cnts", {match_count, cycle_count, err_addr, err_data}, 0);
      reset_n = 1'b1;
      tick();

      // Single-store vectors
      for (int i = 0; i < 7; i++) begin
         do_reset();
         cfg_write(0, vecs[i].t_addr, vecs[i].t_data);
         do_start(vecs[i].exp_cnt);
         tick();
         store(vecs[i].s_addr, vecs[i].s_data);
         check({vecs[i].name, "_pass"}, pass, vecs[i].e_pass);
         check({vecs[i].name, "_fail"}, fail, vecs[i].e_fail);
         check({vecs[i].name, "_done"}, done, vecs[i].e_done);
         check({vecs[i].name, "_over"}, overrun, vecs[i].e_over);
         check({vecs[i].name, "_match"}, match_count, vecs[i].e_match);
         check({vecs[i].name, "_err"}, {err_addr, err_data}, {vecs[i].e_eaddr, vecs[i].e_edata});
         check({vecs[i].name, "_cyc"}, cycle_count, (vecs[i].exp_cnt == 0) ? 1 : 2);
      end

      // T1: two stores at cycles 3 and 9 after start
      do_reset();
      cfg_write(0, 32'h54, 32'h7);
      cfg_write(1, 32'h50, 32'h7);
      do_start(2);
      ticks(2);
      store(32'h54, 32'h7);
      ticks(5);
      check("t1_mid_pass", pass, 0);
      check("t1_mid_match", match_count, 1);
      store(32'h50, 32'h7);
      check("t1_pass", {pass, fail, done}, 3'b101);
      check("t1_match", match_count, 2);
      check("t1_cyc", cycle_count, 9);

      // T3: watchdog with no stores
      do_reset();
      do_start(1);
      ticks(MAXC - 1);
      check("t3_pre", {timeout, done}, 2'b00);
      tick();
      check("t3_tout", {timeout, done, pass, fail}, 4'b1100);
      check("t3_cyc", cycle_count, MAXC);
      ticks(3);
      check("t3_sat", cycle_count, MAXC);

      // Completing store on the watchdog edge wins
      do_reset();
      do_start(1);
      ticks(MAXC - 1);
      store(32'h54, 32'h7);
      check("tie_pass", {pass, timeout, done}, 3'b101);
      check("tie_pass_cyc", cycle_count, MAXC);

      // Mismatch on the watchdog edge wins
      do_reset();
      do_start(1);
      ticks(MAXC - 1);
      store(32'h54, 32'h9);
      check("tie_fail", {fail, timeout, done}, 3'b101);
      check("tie_fail_err", err_data, 32'h9);

      // T4: store held for two consecutive cycles
      do_reset();
      cfg_write(0, 32'h54, 32'h7);
      cfg_write(1, 32'h60, 32'h1);
      do_start(2);
      tick();
      bus.memwrite = 1'b1; bus.aluout = 32'h54; bus.writedata = 32'h7;
      ticks(2);
      bus.memwrite = 1'b0;
`ifdef MIPS_STORE_CHECKER_DUP_FILTER_EN
      check("t4_match", match_count, 1);
      check("t4_fail", fail, 0);
      store(32'h60, 32'h1);
      check("t4_pass", pass, 1);
`else
      check("t4_fail", fail, 1);
      check("t4_match", match_count, 1);
      check("t4_err", {err_addr, err_data}, {32'h54, 32'h7});
`endif

      // T5: overrun after pass, then restart
      do_reset();
      do_start(1);
      store(32'h54, 32'h7);
      check("t5_pass", pass, 1);
      store(32'h70, 32'h2);
      check("t5_over", {overrun, pass, fail}, 3'b110);
      bus.memwrite = 1'b1; bus.aluout = 32'h54; bus.writedata = 32'h7;
      do_start(1);
      check("t5_restart", {done, pass, fail, timeout, overrun}, 5'b0);
      check("t5_restart_cnt", {match_count, cycle_count}, 0);
      cfg_write(0, 32'h99, 32'h99);
      store(32'h54, 32'h7);
      check("t5_repass", {pass, match_count}, {1'b1, 4'd1});

      // T6: asynchronous reset mid-run; table survives; out-of-range index dropped
      do_reset();
      do_start(2);
      store(32'h54, 32'h7);
      check("t6_pre", match_count, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_async", {done, pass, fail, timeout, overrun, match_count, cycle_count}, 0);
      #1;
      reset_n = 1'b1;
      tick();
      cfg_write(4'd8, 32'hAA, 32'hBB);
      do_start(2);
      store(32'h54, 32'h7);
      store(32'h60, 32'h1);
      check("t6_table", {pass, fail, match_count}, {1'b1, 1'b0, 4'd2});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
